// File: rtl/bin_streamer.sv
// bin_streamer -- serialises one DFT magnitude frame into a 16-bit beat stream.
//
// A frame of NB = BPO*OC unsigned ND-bit magnitudes is captured into an
// internal snapshot on an accepted binsValid strobe. It is then streamed
// one bin per beat, lowest bin first. Each beat carries
// sat16(bin >> SHIFT).
//
// Optional feature: define BIN_STREAMER_HEADER_EN to prefix every frame
// with one header beat {8'hA5, frame_count}. When the macro is undefined,
// the HEADER state is absent and outHeader is tied low.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   inBins       in   ND*NB flattened magnitudes; bin k at [k*ND +: ND]
//   binsValid    in   one-cycle strobe: inBins holds a complete frame
//   outReady     in   downstream accepts the current beat
//   outValid     out  outData/outIndex/outLast/outHeader are valid
//   outData      out  scaled, saturated magnitude or header word
//   outIndex     out  bin index of the current beat (0 on header)
//   outLast      out  current beat is bin NB-1
//   outHeader    out  current beat is the header word
//   busy         out  state is not IDLE
//   frameDropped out  one-cycle pulse: a binsValid was ignored
//   dropCount    out  saturating count of dropped frames
//
// Handshake: a beat transfers on a rising edge where outValid and outReady
// are both high. While outValid is high and outReady is low, every output
// field holds. outValid stays high from the first beat of a frame to the
// last beat of that frame.
module bin_streamer #(
   parameter int BPO   = 24,
   parameter int OC    = 5,
   parameter int ND    = 36,
   parameter int SHIFT = 8,
   localparam int NB   = BPO * OC,
   localparam int IW   = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ND*NB-1:0]   inBins,
   input  logic               binsValid,
   input  logic               outReady,
   output logic               outValid,
   output logic [15:0]        outData,
   output logic [IW-1:0]      outIndex,
   output logic               outLast,
   output logic               outHeader,
   output logic               busy,
   output logic               frameDropped,
   output logic [7:0]         dropCount
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

`ifdef BIN_STREAMER_HEADER_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEADER = 2'd1, ST_STREAM = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd2} state_t;
`endif

   state_t          state_q;
   logic [IW-1:0]   cnt_q;
   logic [ND-1:0]   snap_q [NB];
   logic            valid_q;
   logic [15:0]     data_q;
   logic [IW-1:0]   index_q;
   logic            last_q;
   logic            dropped_q;
   logic [7:0]      drop_cnt_q;
   logic [7:0]      frame_cnt_q;
`ifdef BIN_STREAMER_HEADER_EN
   logic            header_q;
`endif

   logic            accept_d;
   logic            drop_d;
   logic            xfer_d;
   logic [IW-1:0]   next_cnt_d;
   logic [ND-1:0]   rd_word_d;
   logic [15:0]     next_sat_d;
`ifndef BIN_STREAMER_HEADER_EN
   logic [15:0]     first_sat_d;
`endif

   function automatic logic [15:0] sat16(input logic [ND-1:0] v);
      logic [ND-1:0] s;
      s = v >> SHIFT;
      if (s > ND'(16'hFFFF)) return 16'hFFFF;
      return s[15:0];
   endfunction

   assign accept_d   = (state_q == ST_IDLE) && binsValid;
   assign drop_d     = (state_q != ST_IDLE) && binsValid;
   assign xfer_d     = valid_q && outReady;
   assign next_cnt_d = cnt_q + 1'b1;

   // Output fields are registered, so the word for the beat after the
   // current one is fetched from the snapshot a cycle ahead. Leaving HEADER
   // (or the final STREAM beat, whose fetch is unused) reads bin 0.
   always_comb begin
      rd_word_d = snap_q[0];
      if (state_q == ST_STREAM && cnt_q != LAST_IDX) rd_word_d = snap_q[next_cnt_d];
   end

   assign next_sat_d = sat16(rd_word_d);
`ifndef BIN_STREAMER_HEADER_EN
   // Without a header the first beat is bin 0 straight from the input,
   // because the snapshot is being written on the same edge.
   assign first_sat_d = sat16(inBins[ND-1:0]);
`endif

   // Snapshot: only written on an accepted frame, never reset.
   always_ff @(posedge clk) begin
      if (!rst && accept_d) begin
         for (int k = 0; k < NB; k++) snap_q[k] <= inBins[k*ND +: ND];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         index_q     <= '0;
         last_q      <= 1'b0;
         dropped_q   <= 1'b0;
         drop_cnt_q  <= '0;
         frame_cnt_q <= '0;
`ifdef BIN_STREAMER_HEADER_EN
         header_q    <= 1'b0;
`endif
      end else begin
         dropped_q <= drop_d;
         if (drop_d && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;

         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  frame_cnt_q <= frame_cnt_q + 8'd1;
                  cnt_q       <= '0;
                  valid_q     <= 1'b1;
                  index_q     <= '0;
`ifdef BIN_STREAMER_HEADER_EN
                  state_q     <= ST_HEADER;
                  header_q    <= 1'b1;
                  data_q      <= {8'hA5, frame_cnt_q + 8'd1};
                  last_q      <= 1'b0;
`else
                  state_q     <= ST_STREAM;
                  data_q      <= first_sat_d;
                  last_q      <= (LAST_IDX == '0);
`endif
               end
            end
`ifdef BIN_STREAMER_HEADER_EN
            ST_HEADER: begin
               if (xfer_d) begin
                  state_q  <= ST_STREAM;
                  cnt_q    <= '0;
                  header_q <= 1'b0;
                  data_q   <= next_sat_d;
                  index_q  <= '0;
                  last_q   <= (LAST_IDX == '0);
               end
            end
`endif
            ST_STREAM: begin
               if (xfer_d) begin
                  if (cnt_q == LAST_IDX) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     index_q <= '0;
                     last_q  <= 1'b0;
                  end else begin
                     cnt_q   <= next_cnt_d;
                     data_q  <= next_sat_d;
                     index_q <= next_cnt_d;
                     last_q  <= (next_cnt_d == LAST_IDX);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               valid_q <= 1'b0;
               data_q  <= '0;
               index_q <= '0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign outValid     = valid_q;
   assign outData      = data_q;
   assign outIndex     = index_q;
   assign outLast      = last_q;
   assign busy         = (state_q != ST_IDLE);
   assign frameDropped = dropped_q;
   assign dropCount    = drop_cnt_q;
`ifdef BIN_STREAMER_HEADER_EN
   assign outHeader    = header_q;
`else
   assign outHeader    = 1'b0;
`endif

endmodule

// File: tb/tb_bin_streamer.sv
// Testbench for bin_streamer: scoreboard of expected beats, one task per
// scenario, summary line at the end.
module tb_bin_streamer;

   localparam int BPO   = 24;
   localparam int OC    = 5;
   localparam int ND    = 36;
   localparam int SHIFT = 8;
   localparam int NB    = BPO * OC;
   localparam int IW    = $clog2(NB);
`ifdef BIN_STREAMER_HEADER_EN
   localparam int HOFF  = 1;
`else
   localparam int HOFF  = 0;
`endif
   localparam int NBT   = NB + HOFF;
   localparam int EW    = 2 + IW + 16;

   logic               clk;
   logic               rst;
   logic [ND*NB-1:0]   in_bins;
   logic               bins_valid;
   logic               out_ready;
   logic               out_valid;
   logic [15:0]        out_data;
   logic [IW-1:0]      out_index;
   logic               out_last;
   logic               out_header;
   logic               busy;
   logic               frame_dropped;
   logic [7:0]         drop_count;

   bin_streamer #(.BPO(BPO), .OC(OC), .ND(ND), .SHIFT(SHIFT)) dut (
      .clk          (clk),
      .rst          (rst),
      .inBins       (in_bins),
      .binsValid    (bins_valid),
      .outReady     (out_ready),
      .outValid     (out_valid),
      .outData      (out_data),
      .outIndex     (out_index),
      .outLast      (out_last),
      .outHeader    (out_header),
      .busy         (busy),
      .frameDropped (frame_dropped),
      .dropCount    (drop_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bench state ----------------
   logic [ND-1:0]  bins_m [NB];
   logic [EW-1:0]  exp_q [$];       // {header, last, index, data}
   int             n_tests = 0;
   int             n_fail  = 0;
   logic [7:0]     frame_m = 8'd0;
   logic [7:0]     drop_m  = 8'd0;
   int             ready_mode = 0;
   int             ready_phase = 0;
   bit             hold_pend = 1'b0;
   logic [EW-1:0]  hold_val;

   function automatic logic [15:0] exp_sat(input logic [ND-1:0] v);
      logic [ND-1:0] s;
      s = v >> SHIFT;
      if (s > 36'h0_0000_FFFF) return 16'hFFFF;
      return s[15:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_bins();
      for (int k = 0; k < NB; k++) in_bins[k*ND +: ND] = bins_m[k];
   endtask

   task automatic rand_bins();
      logic [ND-1:0] v;
      for (int k = 0; k < NB; k++) begin
         v = ND'({$urandom(), $urandom()});
         bins_m[k] = v >> $urandom_range(0, 28);
      end
   endtask

   // 0: always ready, 1: 1,0,0,1 repeating, 2: random, 3: stalled
   task automatic drive_ready();
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      ready_phase++;
   endtask

   task automatic set_mode(input int m);
      ready_mode  = m;
      ready_phase = 0;
      drive_ready();
   endtask

   // Scoreboard: runs at the falling edge, when outputs are settled and the
   // beat that the next rising edge will transfer is visible.
   task automatic scoreboard();
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = {out_header, out_last, out_index, out_data};
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend && out_valid) begin
            n_tests++;
            if (act !== hold_val) begin
               n_fail++;
               $display("FAIL hold_stable: got %h required %h", act, hold_val);
            end
         end
         if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: got %h required no beat", act);
            end else begin
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  n_fail++;
                  $display("FAIL beat: got hdr=%b last=%b idx=%0d data=%h required hdr=%b last=%b idx=%0d data=%h",
                           act[EW-1], act[EW-2], act[16 +: IW], act[15:0],
                           exp[EW-1], exp[EW-2], exp[16 +: IW], exp[15:0]);
               end
            end
         end
         hold_pend = out_valid && !out_ready;
         hold_val  = act;
      end
   endtask

   // Advance one cycle; returns 1 time unit after the rising edge.
   task automatic step();
      @(negedge clk);
      scoreboard();
      @(posedge clk);
      #1;
      drive_ready();
   endtask

   task automatic push_frame();
      logic [EW-1:0] e;
      frame_m = frame_m + 8'd1;
`ifdef BIN_STREAMER_HEADER_EN
      e = {1'b1, 1'b0, IW'(0), 8'hA5, frame_m};
      exp_q.push_back(e);
`endif
      for (int k = 0; k < NB; k++) begin
         e = {1'b0, (k == NB - 1), IW'(k), exp_sat(bins_m[k])};
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse_valid();
      bins_valid = 1'b1;
      step();
      bins_valid = 1'b0;
   endtask

   task automatic drain(input int budget, output int cycles);
      cycles = 0;
      while (exp_q.size() > 0 && cycles < budget) begin
         step();
         cycles++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      bins_valid = 1'b0;
      in_bins = '0;
      set_mode(0);
      repeat (3) step();
      n_tests++;
      if ({out_valid, busy, out_last, out_header, frame_dropped} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 00000",
                  {out_valid, busy, out_last, out_header, frame_dropped});
      end
      n_tests++;
      if (out_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0000", out_data);
      end
      n_tests++;
      if (out_index !== '0) begin
         n_fail++;
         $display("FAIL reset_index: got %0d required 0", out_index);
      end
      n_tests++;
      if (drop_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_dropcount: got %0d required 0", drop_count);
      end
      rst = 1'b0;
      frame_m = 8'd0;
      drop_m = 8'd0;
      step();
   endtask

   task automatic test_basic();
      int cyc;
      for (int k = 0; k < NB; k++) bins_m[k] = ND'(k) << 8;
      load_bins();
      set_mode(0);
      push_frame();
      pulse_valid();
      n_tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency: got valid=%b busy=%b required 1 1", out_valid, busy);
      end
      drain(NBT + 50, cyc);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL basic_timeout: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
      n_tests++;
      if (cyc != NBT) begin
         n_fail++;
         $display("FAIL basic_back_to_back: got %0d cycles required %0d", cyc, NBT);
      end
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end_idle: got valid=%b busy=%b required 0 0", out_valid, busy);
      end
      n_tests++;
      if (out_data !== 16'h0 || out_index !== '0) begin
         n_fail++;
         $display("FAIL basic_idle_fields: got data=%h idx=%0d required 0000 0", out_data, out_index);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      logic [EW-1:0] e;
      rand_bins();
      bins_m[3] = 36'h0_0123_4567;
      bins_m[4] = 36'h0_00FF_FF00;
      bins_m[5] = 36'h0_0000_1200;
      load_bins();
      set_mode(2);
      push_frame();
      // Anchor the three called-out bins to literal results.
      e = exp_q[HOFF + 3]; e[15:0] = 16'hFFFF; exp_q[HOFF + 3] = e;
      e = exp_q[HOFF + 4]; e[15:0] = 16'hFFFF; exp_q[HOFF + 4] = e;
      e = exp_q[HOFF + 5]; e[15:0] = 16'h0012; exp_q[HOFF + 5] = e;
      pulse_valid();
      drain(4 * NBT + 200, cyc);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sat_timeout: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      bit busy_dropped;
      rand_bins();
      load_bins();
      set_mode(1);
      push_frame();
      pulse_valid();
      cyc = 0;
      busy_dropped = 1'b0;
      while (exp_q.size() > 0 && cyc < 4 * NBT + 50) begin
         step();
         cyc++;
         if (exp_q.size() > 0 && busy !== 1'b1) busy_dropped = 1'b1;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_timeout: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
      n_tests++;
      if (busy_dropped) begin
         n_fail++;
         $display("FAIL bp_busy: got busy low mid-frame required high");
      end
      set_mode(0);
      step();
   endtask

   task automatic test_drop();
      int m;
      int cyc;
      rand_bins();
      load_bins();
      set_mode(0);
      push_frame();
      pulse_valid();
      m = 0;
      while (exp_q.size() > 0 && m < NBT + 50) begin
         if (m == 30) begin
            // New data on the input must not reach the snapshot.
            rand_bins();
            load_bins();
            bins_valid = 1'b1;
            drop_m = drop_m + 8'd1;
         end
         if (m == NBT - 1) begin
            bins_valid = 1'b1;
            drop_m = drop_m + 8'd1;
         end
         step();
         m++;
         bins_valid = 1'b0;
         if (m == 31) begin
            n_tests++;
            if (frame_dropped !== 1'b1 || drop_count !== drop_m) begin
               n_fail++;
               $display("FAIL drop_mid: got pulse=%b count=%0d required 1 %0d", frame_dropped, drop_count, drop_m);
            end
         end
         if (m == 32) begin
            n_tests++;
            if (frame_dropped !== 1'b0) begin
               n_fail++;
               $display("FAIL drop_pulse_width: got %b required 0", frame_dropped);
            end
         end
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drop_timeout: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
      n_tests++;
      if (frame_dropped !== 1'b1 || drop_count !== 8'd2 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_last: got pulse=%b count=%0d valid=%b required 1 2 0",
                  frame_dropped, drop_count, out_valid);
      end
      // Next strobe in IDLE is accepted and streams the new input.
      push_frame();
      pulse_valid();
      drain(NBT + 50, cyc);
      n_tests++;
      if (exp_q.size() != 0 || drop_count !== drop_m) begin
         n_fail++;
         $display("FAIL drop_next_frame: got left=%0d count=%0d required 0 %0d",
                  exp_q.size(), drop_count, drop_m);
         exp_q.delete();
      end
   endtask

   task automatic test_stall_saturate();
      int cyc;
      rand_bins();
      load_bins();
      set_mode(3);
      push_frame();
      bins_valid = 1'b1;
      step();
      for (int i = 0; i < 260; i++) begin
         step();
         if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
      end
      bins_valid = 1'b0;
      step();
      n_tests++;
      if (drop_count !== 8'hFF || drop_count !== drop_m) begin
         n_fail++;
         $display("FAIL drop_saturate: got %0d required 255", drop_count);
      end
      n_tests++;
      if (out_valid !== 1'b1 || exp_q.size() != NBT) begin
         n_fail++;
         $display("FAIL stall_hold: got valid=%b left=%0d required 1 %0d", out_valid, exp_q.size(), NBT);
      end
      set_mode(2);
      drain(4 * NBT + 200, cyc);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_timeout: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
      set_mode(0);
      step();
   endtask

   task automatic test_reset_mid();
      int cyc;
      rand_bins();
      load_bins();
      set_mode(0);
      push_frame();
      pulse_valid();
      repeat (50) step();
      rst = 1'b1;
      bins_valid = 1'b1;
      step();
      rst = 1'b0;
      bins_valid = 1'b0;
      exp_q.delete();
      frame_m = 8'd0;
      drop_m = 8'd0;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got valid=%b busy=%b required 0 0", out_valid, busy);
      end
      step();
      n_tests++;
      if (drop_count !== 8'd0 || frame_dropped !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_nodrop: got count=%0d pulse=%b valid=%b required 0 0 0",
                  drop_count, frame_dropped, out_valid);
      end
      repeat (4) step();
      push_frame();
      pulse_valid();
      drain(NBT + 50, cyc);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_restart: got %0d beats left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      bins_valid = 1'b0;
      out_ready = 1'b1;
      in_bins = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_drop();
      test_stall_saturate();
      test_reset_mid();
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_streamer.md
BIN_STREAMER -- requirements
Module: bin_streamer

Interface
REQ-001 Parameters SHALL be:
- BPO, default 24, bins per octave.
- OC, default 5, octave count.
- ND, default 36, input magnitude width.
- SHIFT, default 8, right-shift applied before saturation.
- NB SHALL be a localparam equal to BPO*OC.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- inBins  in  ND x NB  unsigned magnitude array from the DFT; index 0 is the lowest-frequency bin.
- binsValid  in  1  one-cycle strobe: inBins holds a complete, stable frame.
- outReady  in  1  downstream accepts the current beat.
- outValid  out  1  outData/outIndex/outLast/outHeader are valid.
- outData  out  16  scaled, saturated magnitude, or header word.
- outIndex  out  clog2(NB)  bin index of the current beat; 0 on the header beat.
- outLast  out  1  current beat is bin NB-1.
- outHeader  out  1  current beat is the header word.
- busy  out  1  high whenever the state is not IDLE.
- frameDropped  out  1  one-cycle pulse: binsValid was ignored.
- dropCount  out  8  saturating count of dropped frames.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, HEADER (present only when BIN_STREAMER_HEADER_EN is defined) and STREAM.
REQ-005 In IDLE, binsValid SHALL copy all NB inBins words into an internal snapshot on that edge; inBins SHALL NOT be sampled again until the next accepted frame.
REQ-006 In IDLE, binsValid SHALL move the state to HEADER (macro defined) or to STREAM (macro undefined), with the bin counter set to 0.
REQ-007 outValid SHALL rise in the cycle after the accepting binsValid edge (latency 1).
REQ-008 A beat SHALL transfer on a rising edge where outValid and outReady are both high.
REQ-009 While outValid is high and outReady is low, outData, outIndex, outLast and outHeader SHALL hold stable.
REQ-010 STREAM beat k SHALL carry outIndex=k and outData=sat16(snapshot[k] >> SHIFT); sat16 SHALL yield 16'hFFFF when the shifted value exceeds 16'hFFFF.
REQ-011 A transfer in STREAM with bin counter < NB-1 SHALL increment the counter.
REQ-012 A transfer with bin counter = NB-1 (outLast=1) SHALL return the state to IDLE; outValid SHALL be low in the following cycle.
REQ-013 binsValid while busy SHALL be ignored, including in the cycle the last beat transfers. The snapshot SHALL stay unchanged, frameDropped SHALL pulse in the next cycle, and dropCount SHALL increment, saturating at 255.
REQ-014 outValid SHALL be low in IDLE.
REQ-015 In IDLE, outData and outIndex SHALL hold 0.
REQ-016 An 8-bit frame counter SHALL increment on each accepted frame and wrap from 255 to 0.
REQ-017 The bench SHALL be able to stall outReady indefinitely; the block SHALL NOT lose, duplicate or reorder beats under stall.

Reset
REQ-018 rst SHALL force:
- state to IDLE; bin counter to 0;
- outValid, outLast, outHeader, busy and frameDropped to 0;
- outData, outIndex, dropCount and the frame counter to 0.
REQ-019 rst asserted mid-frame SHALL abort the frame with no further beats; the snapshot contents after reset are don't-care.
REQ-020 rst SHALL take priority over a simultaneous binsValid, which SHALL be neither accepted nor counted as dropped.

Configuration
REQ-021 Macro BIN_STREAMER_HEADER_EN SHALL control the header beat.
REQ-022 With BIN_STREAMER_HEADER_EN defined, each frame SHALL begin with one HEADER beat:
- outHeader=1, outIndex=0;
- outData={8'hA5, frame counter value after the increment for this frame};
- a transfer moves the state to STREAM with bin counter 0.
- A frame SHALL be NB+1 beats.
REQ-023 With BIN_STREAMER_HEADER_EN undefined, the HEADER state and its logic SHALL be absent, outHeader SHALL be tied 0, and a frame SHALL be NB beats.

Verification
REQ-024 Basic frame: outReady=1, inBins[k]=k<<8, pulse binsValid once -> 120 beats on consecutive cycles, outData=k, outIndex=k, outLast only on index 119; with the header macro, a leading beat 16'hA501.
REQ-025 Saturation: inBins[3]=36'h0_0123_4567, SHIFT=8 -> beat 3 outData=16'hFFFF; inBins[4]=36'h0_00FF_FF00 -> beat 4 outData=16'hFFFF; inBins[5]=36'h0_0000_1200 -> beat 5 outData=16'h0012.
REQ-026 Backpressure: outReady toggles 1,0,0,1 repeating -> all 120 beats delivered in order; data held during low-ready cycles; busy high throughout.
REQ-027 Drop: binsValid mid-frame, then again in the cycle the last beat transfers -> two frameDropped pulses, dropCount=2, streamed data from the first snapshot only; the next binsValid in IDLE is accepted.
REQ-028 Reset mid-frame: rst for one cycle at beat 50 -> outValid=0 and busy=0 the next cycle; dropCount=0; a new binsValid starts at index 0 (header frame count 1 with the macro).
